scl180_sparecell_ctrl: RTL and testbench
========================================

SCL180_SPARECELL_CTRL -- requirements
Module: scl180_sparecell_ctrl

Interface
REQ-001 SHALL have parameter NCELLS, default 4: number of managed spare-cell slots, legal range 1..8.
REQ-002 SHALL have parameter SETTLE_CYC, default 8: apply settle count in clk cycles, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the only clock.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_req, input, 1 bit: config access request.
REQ-006 SHALL have port cfg_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port cfg_addr, input, 2 bits: 0 KEY, 1 MASK, 2 STATUS, 3 CTRL.
REQ-008 SHALL have port cfg_wdata, input, 8 bits: write data.
REQ-009 SHALL have port cfg_ack, output, 1 bit: single-cycle access acknowledge.
REQ-010 SHALL have port cfg_rdata, output, 8 bits: read data, valid while cfg_ack=1.
REQ-011 SHALL have port spare_lo, input, NCELLS bits: tie-low outputs returned from the spare cells.
REQ-012 SHALL have port spare_en, output, NCELLS bits: applied enable mask to the spare-cell slots.
REQ-013 SHALL have port busy, output, 1 bit: high while in APPLY.

Function
REQ-014 FSM states SHALL be LOCKED, UNLOCKED and APPLY.
REQ-015 An access SHALL be sampled on a cycle with cfg_req=1, cfg_ack=0; cfg_ack SHALL pulse exactly one cycle later.
REQ-016 A requester holding cfg_req through the ack cycle SHALL NOT produce a second ack; cfg_req must drop for at least one cycle between accesses.
REQ-017 Every sampled access SHALL be acked, including ignored or erroneous ones.
REQ-018 Write KEY=0xA5 in LOCKED SHALL move the FSM to UNLOCKED.
REQ-019 Write KEY of any other value in LOCKED SHALL keep the FSM in LOCKED and set key_err.
REQ-020 Write KEY in UNLOCKED SHALL return the FSM to LOCKED, whatever the value.
REQ-021 Write MASK in UNLOCKED SHALL load shadow[NCELLS-1:0] from cfg_wdata; upper wdata bits are ignored.
REQ-022 Write MASK in LOCKED SHALL be ignored and set key_err.
REQ-023 Write CTRL with bit0=1 in UNLOCKED SHALL enter APPLY, load the counter with SETTLE_CYC-1 and drive busy=1 on the next cycle.
REQ-024 Write CTRL with bit0=0 SHALL be a no-op.
REQ-025 In APPLY, the counter SHALL decrement each cycle; on the cycle it reads 0, spare_en SHALL load shadow, busy SHALL clear and the FSM SHALL go to LOCKED.
REQ-026 Total APPLY latency from the ack of the CTRL write to spare_en update SHALL be SETTLE_CYC cycles.
REQ-027 Any write during APPLY SHALL be ignored and set busy_err.
REQ-028 Reads during APPLY SHALL be serviced normally.
REQ-029 Read data SHALL be: KEY 0x00; MASK zero-extended shadow; STATUS {3'b0, tie_fault, busy_err, key_err, fsm_unlocked, busy}; CTRL 0x00.
REQ-030 A write to STATUS SHALL clear the sticky bits key_err, busy_err and tie_fault where the corresponding wdata bit is 1 (W1C).
REQ-031 If set and clear of a sticky bit occur in the same cycle, set SHALL win.
REQ-032 spare_en SHALL change only at APPLY completion, never directly on a MASK write.

Reset
REQ-033 resetn=0 SHALL asynchronously force: FSM LOCKED, shadow=0, spare_en=0, counter=0, busy=0, cfg_ack=0, cfg_rdata=0, all sticky bits 0.
REQ-034 Reset asserted mid-APPLY SHALL abort the apply; spare_en stays 0 after release.
REQ-035 An access in flight when reset asserts SHALL be dropped without ack.
REQ-036 Reset release SHALL be synchronised internally by a 2-flop synchroniser; the first access is sampled no earlier than the 2nd clk edge after release.

Configuration
REQ-037 Macro SPARECELL_TIECHK_EN defined: spare_lo SHALL be registered each cycle; any bit=1 SHALL set sticky tie_fault, and an APPLY completing while tie_fault=1 SHALL leave spare_en unchanged.
REQ-038 Macro SPARECELL_TIECHK_EN undefined: spare_lo SHALL be unused, tie_fault SHALL read 0 and APPLY SHALL always load spare_en.

Verification
REQ-039 Reset, then read STATUS -> rdata=0x00, spare_en=0, ack one cycle after req.
REQ-040 Write KEY 0xA5, MASK 0x0B, CTRL 0x01 (NCELLS=4, SETTLE_CYC=8) -> busy=1 for 8 cycles, then spare_en=4'b1011 and STATUS=0x00.
REQ-041 In LOCKED, write KEY 0x5A then MASK 0x0F -> both acked, STATUS=0x04, spare_en unchanged; write STATUS 0x04 -> STATUS=0x00.
REQ-042 Write during APPLY -> acked and ignored, STATUS bit3=1; pulse resetn low at APPLY cycle 4 -> spare_en=0, busy=0.
REQ-043 With SPARECELL_TIECHK_EN defined, force spare_lo[2]=1 for one cycle, then apply mask 0x03 -> STATUS bit4=1 and spare_en unchanged; without the macro -> spare_en=0x03.

Source files
------------

// File: rtl/scl180_sparecell_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : scl180_sparecell_ctrl
// Brief    : Key-locked spare-cell enable controller with a timed apply phase.
//            Optional macro SPARECELL_TIECHK_EN enables the tie-low fault check.
// Revision : 1.0 - initial release
// ============================================================================
module scl180_sparecell_ctrl #(
    parameter int NCELLS     = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_req,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic              cfg_ack,
    output logic [7:0]        cfg_rdata,
    input  logic [NCELLS-1:0] spare_lo,
    output logic [NCELLS-1:0] spare_en,
    output logic              busy
);

    localparam logic [1:0] c_LOCKED   = 2'd0;
    localparam logic [1:0] c_UNLOCKED = 2'd1;
    localparam logic [1:0] c_APPLY    = 2'd2;

    localparam logic [1:0] c_A_KEY    = 2'd0;
    localparam logic [1:0] c_A_MASK   = 2'd1;
    localparam logic [1:0] c_A_STATUS = 2'd2;
    localparam logic [1:0] c_A_CTRL   = 2'd3;

    localparam logic [7:0] c_KEY_VAL     = 8'hA5;
    localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    logic [1:0]        r_rst_sync;
    logic [1:0]        r_state;
    logic [NCELLS-1:0] r_shadow;
    logic [NCELLS-1:0] r_spare_en;
    logic [7:0]        r_cnt;
    logic              r_busy;
    logic              r_ack;
    logic [7:0]        r_rdata;
    logic              r_held;
    logic              r_key_err;
    logic              r_busy_err;

    logic              w_sample;
    logic              w_wr;
    logic              w_set_key;
    logic              w_set_busy;
    logic              w_clr_en;
    logic              w_tie_fault;
    logic [7:0]        w_mask_rd;
    logic [7:0]        w_rd_val;

    // Release is delayed two edges so no access is taken right after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // r_held blocks a second sample while the requester keeps cfg_req high.
    assign w_sample = cfg_req & ~r_ack & ~r_held & r_rst_sync[1];
    assign w_wr     = w_sample & cfg_we;

    always_comb begin
        w_set_key  = 1'b0;
        w_set_busy = 1'b0;
        w_clr_en   = 1'b0;
        if (w_wr) begin
            if (r_state == c_APPLY) begin
                w_set_busy = 1'b1;
            end else begin
                if (r_state == c_LOCKED &&
                    ((cfg_addr == c_A_KEY && cfg_wdata != c_KEY_VAL) || cfg_addr == c_A_MASK))
                    w_set_key = 1'b1;
                if (cfg_addr == c_A_STATUS)
                    w_clr_en = 1'b1;
            end
        end
    end

    always_comb begin
        w_mask_rd             = 8'h00;
        w_mask_rd[NCELLS-1:0] = r_shadow;
        case (cfg_addr)
            c_A_MASK:   w_rd_val = w_mask_rd;
            c_A_STATUS: w_rd_val = {3'b000, w_tie_fault, r_busy_err, r_key_err,
                                    (r_state == c_UNLOCKED), r_busy};
            default:    w_rd_val = 8'h00;
        endcase
    end

`ifdef SPARECELL_TIECHK_EN
    logic [NCELLS-1:0] r_spare_lo_q;
    logic              r_tie_fault;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_spare_lo_q <= '0;
            r_tie_fault  <= 1'b0;
        end else begin
            r_spare_lo_q <= spare_lo;
            r_tie_fault  <= (r_tie_fault & ~(w_clr_en & cfg_wdata[4])) | (|r_spare_lo_q);
        end
    end

    assign w_tie_fault = r_tie_fault;
`else
    logic w_spare_lo_unused;
    assign w_spare_lo_unused = ^spare_lo;
    assign w_tie_fault       = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_LOCKED;
            r_shadow   <= '0;
            r_spare_en <= '0;
            r_cnt      <= 8'd0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_rdata    <= 8'h00;
            r_held     <= 1'b0;
            r_key_err  <= 1'b0;
            r_busy_err <= 1'b0;
        end else begin
            r_ack      <= w_sample;
            r_rdata    <= (w_sample && !cfg_we) ? w_rd_val : 8'h00;
            r_held     <= cfg_req & (r_held | w_sample);
            r_key_err  <= (r_key_err  & ~(w_clr_en & cfg_wdata[2])) | w_set_key;
            r_busy_err <= (r_busy_err & ~(w_clr_en & cfg_wdata[3])) | w_set_busy;

            case (r_state)
                c_LOCKED: begin
                    if (w_wr && cfg_addr == c_A_KEY && cfg_wdata == c_KEY_VAL)
                        r_state <= c_UNLOCKED;
                end
                c_UNLOCKED: begin
                    if (w_wr) begin
                        case (cfg_addr)
                            c_A_KEY:  r_state  <= c_LOCKED;
                            c_A_MASK: r_shadow <= cfg_wdata[NCELLS-1:0];
                            c_A_CTRL: begin
                                if (cfg_wdata[0]) begin
                                    r_state <= c_APPLY;
                                    r_cnt   <= c_SETTLE_LOAD;
                                    r_busy  <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                c_APPLY: begin
                    if (r_cnt == 8'd0) begin
                        if (!w_tie_fault)
                            r_spare_en <= r_shadow;
                        r_busy  <= 1'b0;
                        r_state <= c_LOCKED;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= c_LOCKED;
            endcase
        end
    end

    assign cfg_ack   = r_ack;
    assign cfg_rdata = r_rdata;
    assign spare_en  = r_spare_en;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_scl180_sparecell_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_scl180_sparecell_ctrl
// Brief    : Directed self-checking bench for scl180_sparecell_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scl180_sparecell_ctrl;

    localparam int NCELLS     = 4;
    localparam int SETTLE_CYC = 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cfg_req = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_addr = 2'd0;
    logic [7:0]        cfg_wdata = 8'h00;
    logic              cfg_ack;
    logic [7:0]        cfg_rdata;
    logic [NCELLS-1:0] spare_lo = '0;
    logic [NCELLS-1:0] spare_en;
    logic              busy;

    int errors = 0;
    int checks = 0;

    scl180_sparecell_ctrl #(.NCELLS(NCELLS), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk(clk), .resetn(resetn), .cfg_req(cfg_req), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack),
        .cfg_rdata(cfg_rdata), .spare_lo(spare_lo), .spare_en(spare_en), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with cfg_req low for one cycle.
    task automatic access(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd);
        cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
        @(posedge clk); @(negedge clk);
        check("ack_pulse", {7'b0, cfg_ack}, 8'h01);
        rd = cfg_rdata;
        cfg_req = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        check("ack_single", {7'b0, cfg_ack}, 8'h00);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] wd);
        logic [7:0] dummy;
        access(1'b1, addr, wd, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        logic [7:0] v;
        access(1'b0, addr, 8'h00, v);
        check(tag, v, exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("apply_timeout", {7'b0, busy}, 8'h00);
    endtask

    initial begin
        int n;
        int acks;
        logic early;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_spare_en", {4'b0, spare_en}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_ack", {7'b0, cfg_ack}, 8'h00);
        check("rst_rdata", cfg_rdata, 8'h00);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        rd_check("status_after_rst", 2'd2, 8'h00);

        // Unlock, load mask, apply; spare_en must not follow the MASK write
        wr(2'd0, 8'hA5);
        rd_check("status_unlocked", 2'd2, 8'h02);
        wr(2'd1, 8'h0B);
        rd_check("mask_rd", 2'd1, 8'h0B);
        check("en_not_on_mask", {4'b0, spare_en}, 8'h00);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 8'h01;
        @(posedge clk); @(negedge clk);
        check("ctrl_ack", {7'b0, cfg_ack}, 8'h01);
        check("busy_on_ack", {7'b0, busy}, 8'h01);
        cfg_req = 1'b0; cfg_we = 1'b0;
        n = 1;
        early = 1'b0;
        while (n < 40) begin
            if (spare_en !== 4'b0000) early = 1'b1;
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        check("busy_cycles", 8'(n), 8'(SETTLE_CYC));
        check("en_not_early", {7'b0, early}, 8'h00);
        check("spare_en_applied", {4'b0, spare_en}, 8'h0B);
        rd_check("status_after_apply", 2'd2, 8'h00);

        // Locked-state errors and W1C
        wr(2'd0, 8'h5A);
        rd_check("status_bad_key", 2'd2, 8'h04);
        wr(2'd1, 8'h0F);
        rd_check("status_locked_mask", 2'd2, 8'h04);
        rd_check("mask_unchanged", 2'd1, 8'h0B);
        check("en_unchanged", {4'b0, spare_en}, 8'h0B);
        wr(2'd2, 8'h04);
        rd_check("status_w1c", 2'd2, 8'h00);
        rd_check("key_reads_zero", 2'd0, 8'h00);
        wr(2'd0, 8'hA5);
        wr(2'd3, 8'h00);
        rd_check("ctrl_noop", 2'd2, 8'h02);
        rd_check("ctrl_reads_zero", 2'd3, 8'h00);
        wr(2'd0, 8'h00);
        rd_check("relock_any_key", 2'd2, 8'h00);

        // Held request yields a single ack
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd2;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (cfg_ack === 1'b1) acks++;
        end
        cfg_req = 1'b0;
        @(negedge clk);
        check("held_req_acks", 8'(acks), 8'h01);

        // Write during APPLY, then reset mid-apply with a request in flight
        wr(2'd0, 8'hA5);
        wr(2'd1, 8'h06);
        wr(2'd3, 8'h01);
        wr(2'd1, 8'h0F);
        rd_check("status_busy_err", 2'd2, 8'h09);
        resetn = 1'b0;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd2;
        #1;
        check("async_busy_clr", {7'b0, busy}, 8'h00);
        check("async_en_clr", {4'b0, spare_en}, 8'h00);
        @(negedge clk);
        check("inflight_no_ack", {7'b0, cfg_ack}, 8'h00);
        resetn = 1'b1;
        @(negedge clk);
        check("no_ack_first_edge", {7'b0, cfg_ack}, 8'h00);
        n = 0;
        while (cfg_ack !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_ack", {7'b0, cfg_ack}, 8'h01);
        check("post_rst_status", cfg_rdata, 8'h00);
        cfg_req = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_en_zero", {4'b0, spare_en}, 8'h00);
        check("abort_busy_zero", {7'b0, busy}, 8'h00);

        // Tie-low check
        spare_lo = 4'b0100;
        @(negedge clk);
        spare_lo = 4'b0000;
        @(negedge clk);
        wr(2'd0, 8'hA5);
        wr(2'd1, 8'h03);
        wr(2'd3, 8'h01);
        wait_idle();
`ifdef SPARECELL_TIECHK_EN
        rd_check("tie_status", 2'd2, 8'h10);
        check("tie_en_held", {4'b0, spare_en}, 8'h00);
`else
        rd_check("tie_status", 2'd2, 8'h00);
        check("tie_en_applied", {4'b0, spare_en}, 8'h03);
`endif
        wr(2'd2, 8'h10);
        rd_check("tie_w1c", 2'd2, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
